ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping an external true dual-port RAM with a 2-entry output buffer.
// Define RAM_FIFO_CTRL_LEVEL_EN to add the registered occupancy output `level`.
module ram_fifo_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATAWIDTH-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATAWIDTH-1:0] m_data,
  output logic [ADDRWIDTH-1:0] ram_addra,
  output logic [DATAWIDTH-1:0] ram_dina,
  output logic                 ram_wea,
  output logic [ADDRWIDTH-1:0] ram_addrb,
  output logic [DATAWIDTH-1:0] ram_dinb,
  output logic                 ram_web,
  input  logic [DATAWIDTH-1:0] ram_doutb
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDRWIDTH+1:0] level
`endif
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] FULL = (ADDRWIDTH+1)'(DEPTH);

  logic                 run;
  logic [ADDRWIDTH-1:0] wptr, rptr;
  logic [ADDRWIDTH:0]   ram_level, ram_level_nxt;
  logic                 inflight;
  logic [1:0]           obuf_level, obuf_level_nxt;
  logic [DATAWIDTH-1:0] obuf0, obuf1;
  logic                 push, pop, rd;
  logic [2:0]           occ;

  // run keeps s_ready low until the first edge after reset release
  assign s_ready = run && (ram_level != FULL);
  assign m_valid = (obuf_level != 2'd0);
  assign m_data  = obuf0;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;
  assign occ  = {1'b0, obuf_level} + {2'b00, inflight};
  assign rd   = (ram_level != '0) && (occ < (3'd2 + {2'b00, pop}));

  assign ram_wea   = push;
  assign ram_addra = wptr;
  assign ram_dina  = s_data;
  assign ram_addrb = rptr;
  assign ram_dinb  = '0;
  assign ram_web   = 1'b0;

  assign ram_level_nxt  = ram_level + (ADDRWIDTH+1)'(push) - (ADDRWIDTH+1)'(rd);
  assign obuf_level_nxt = obuf_level + {1'b0, inflight} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      ram_level  <= '0;
      inflight   <= 1'b0;
      obuf_level <= 2'd0;
      obuf0      <= '0;
      obuf1      <= '0;
    end else begin
      run        <= 1'b1;
      ram_level  <= ram_level_nxt;
      inflight   <= rd;
      obuf_level <= obuf_level_nxt;
      if (push) wptr <= wptr + ADDRWIDTH'(1);
      if (rd)   rptr <= rptr + ADDRWIDTH'(1);
      // inflight means ram_doutb holds the word issued last cycle
      case ({inflight, pop})
        2'b01: obuf0 <= obuf1;
        2'b10: begin
          if (obuf_level == 2'd0) obuf0 <= ram_doutb;
          else                    obuf1 <= ram_doutb;
        end
        2'b11: begin
          if (obuf_level == 2'd1) obuf0 <= ram_doutb;
          else begin
            obuf0 <= obuf1;
            obuf1 <= ram_doutb;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_FIFO_CTRL_LEVEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level <= '0;
    else        level <= (ADDRWIDTH+2)'(ram_level_nxt) + (ADDRWIDTH+2)'(rd)
                         + (ADDRWIDTH+2)'(obuf_level_nxt);
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl (DEPTH=4) against a registered-read dual-port RAM model.
module tb_ram_fifo_ctrl;
  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_dinb, ram_doutb;
  logic          ram_wea, ram_web;
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  logic [AW+1:0] level;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_web(ram_web),
    .ram_doutb(ram_doutb)
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    , .level(level)
`endif
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always_ff @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_web) mem[ram_addrb] <= ram_dinb;
    ram_doutb <= mem[ram_addrb];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboarded transfer of n words; rnd randomizes s_valid and m_ready
  task automatic run_stream(input int n, input bit rnd, input logic [DW-1:0] base);
    logic [DW-1:0] q[$];
    logic [DW-1:0] held = '0;
    int  sent = 0, rcvd = 0, gaps = 0, cyc = 0;
    bit  started = 0, stall = 0;
    while (rcvd < n && cyc < 2000) begin
      s_valid = (sent < n) && (!rnd || ($urandom_range(0, 1) == 1));
      s_data  = base + DW'(sent);
      m_ready = !rnd || ($urandom_range(0, 2) != 0);
      #1;
      if (stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(held));
      end
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        sent++;
      end
      if (m_valid) begin
        started = 1;
        if (m_ready) begin
          if (q.size() == 0) chk("extra_word", 32'(m_data), 32'hFFFF_FFFF);
          else begin
            chk("order", 32'(m_data), 32'(q[0]));
            void'(q.pop_front());
          end
          rcvd++;
        end
      end else if (started) gaps++;
      stall = m_valid && !m_ready;
      held  = m_data;
      step();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("stream_count", 32'(rcvd), 32'(n));
    if (!rnd) chk("stream_gaps", 32'(gaps), 32'd0);
  endtask

  initial begin
    int stale;
    int waited;
    rst_n = 1'b0; s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_wea", 32'(ram_wea), 32'd0);
    s_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // single word: accept E0, issue E1, visible after E2
    s_valid = 1'b1; s_data = 16'hA5A5; m_ready = 1'b1;
    #1;
    chk("push_wea", 32'(ram_wea), 32'd1);
    chk("push_addra", 32'(ram_addra), 32'd0);
    chk("push_dina", 32'(ram_dina), 32'hA5A5);
    step();
    s_valid = 1'b0; s_data = 16'hDEAD;
    #1 chk("single_e0", 32'(m_valid), 32'd0);
    step();
    #1 chk("single_e1", 32'(m_valid), 32'd0);
    step();
    #1 chk("single_e2_valid", 32'(m_valid), 32'd1);
    chk("single_e2_data", 32'(m_data), 32'hA5A5);
    step();
    #1 chk("single_e3_valid", 32'(m_valid), 32'd0);

    // fill: DEPTH+2 = 6 words with no consumer
    m_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      s_valid = 1'b1; s_data = DW'(k);
      #1 chk("fill_ready", 32'(s_ready), 32'd1);
      step();
    end
    s_valid = 1'b1; s_data = 16'h00FF;
    repeat (3) begin
      #1 chk("full_ready", 32'(s_ready), 32'd0);
      step();
    end
    s_valid = 1'b0;
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    chk("level_full", 32'(level), 32'd6);
`endif
    m_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("drain_valid", 32'(m_valid), 32'd1);
      chk("drain_data", 32'(m_data), 32'(k));
      step();
`ifdef RAM_FIFO_CTRL_LEVEL_EN
      if (k == 1) chk("level_after_pop", 32'(level), 32'd5);
`endif
    end
    #1 chk("drain_empty", 32'(m_valid), 32'd0);
    m_ready = 1'b0;
    step();

    run_stream(20, 1'b0, 16'h0100);
    repeat (4) step();
    run_stream(50, 1'b1, 16'h0200);
    repeat (4) step();

    // reset with 3 words buffered
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = 16'h0300 + DW'(k);
      step();
    end
    s_valid = 1'b0;
    repeat (2) step();
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd0);
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    chk("mid_rst_level", 32'(level), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("rerun_ready", 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      if (m_valid) stale++;
      step();
    end
    chk("stale_words", 32'(stale), 32'd0);
    s_valid = 1'b1; s_data = 16'h0077;
    step();
    s_valid = 1'b0;
    waited = 0;
    while (!m_valid && waited < 10) begin
      step();
      waited++;
    end
    chk("after_rst_valid", 32'(m_valid), 32'd1);
    chk("after_rst_data", 32'(m_data), 32'h0077);
    step();
    chk("after_rst_empty", 32'(m_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
